// File: rtl/jesd204_pkg.sv
// Shared constants, types and helpers for the JESD204B receive descrambler.
// The self-synchronising polynomial is 1 + x^14 + x^15.
package jesd204_pkg;

    localparam int          SCR_W    = 15;
    localparam logic [14:0] SCR_SEED = 15'h7FFF;
    localparam int          TAP_A    = 14;
    localparam int          TAP_B    = 15;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNCED = 1'b1
    } sync_state_e;

    // Reverses the octet order so that the first line bit lands in bit 31.
    function automatic logic [31:0] octet_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/jesd204_descramble_core.sv
// Purely combinational 32-bit parallel descrambler slice: maps the 15-bit line
// history and one swizzled word to the recovered word and the next history.
module jesd204_descramble_core
    import jesd204_pkg::*;
(
    input  logic [SCR_W-1:0] state_i,
    input  logic [31:0]      sw_i,
    output logic [31:0]      d_o,
    output logic [SCR_W-1:0] next_state_o
);

    logic [SCR_W+31:0] full;

    assign full = {state_i, sw_i};

    // Higher indices of full are older line bits, so full[i+14] and full[i+15]
    // are the bits sent 14 and 15 positions before sw_i[i].
    always_comb begin
        d_o = '0;
        for (int i = 0; i < 32; i++) begin
            d_o[i] = full[i + TAP_B] ^ full[i + TAP_A] ^ sw_i[i];
        end
    end

    assign next_state_o = sw_i[SCR_W-1:0];

endmodule

// File: rtl/jesd204_rx_descrambler.sv
// Single-lane JESD204B receive descrambler with a registered valid/ready output
// stage, descrambler-sync tracking and an all-zero payload checker.
module jesd204_rx_descrambler
    import jesd204_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     check_en,
    input  logic                     clear_err,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_data,
    output logic                     m_synced,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     err_flag
);

    logic [SCR_W-1:0]         state_q;
    logic [SCR_W-1:0]         state_d;
    sync_state_e              sync_q;
    logic                     m_valid_q;
    logic [31:0]              m_data_q;
    logic [31:0]              m_data_d;
    logic                     m_synced_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_d;
    logic                     err_flag_q;
    logic                     err_flag_d;

    logic        in_fire;
    logic        out_fire;
    logic        mismatch;
    logic [31:0] sw;
    logic [31:0] d;

    assign s_ready  = !m_valid_q || m_ready;
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid_q && m_ready;

    assign sw = octet_swap(s_data);

    jesd204_descramble_core u_core (
        .state_i      (state_q),
        .sw_i         (sw),
        .d_o          (d),
        .next_state_o (state_d)
    );

    assign m_data_d = enable ? octet_swap(d) : s_data;

    // History advances on every accepted word, even in bypass.
    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values and simulation matches the netlist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCR_SEED;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_synced_q <= 1'b0;
        end else if (in_fire) begin
            state_q    <= state_d;
            m_valid_q  <= 1'b1;
            m_data_q   <= m_data_d;
            m_synced_q <= enable && (sync_q == SYNCED);
        end else if (m_ready) begin
            m_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= UNSYNC;
        end else begin
            case (sync_q)
                UNSYNC:  if (enable && in_fire) sync_q <= SYNCED;
                SYNCED:  if (!enable)           sync_q <= UNSYNC;
                default:                        sync_q <= UNSYNC;
            endcase
        end
    end

    assign mismatch = out_fire && check_en && m_synced_q && (m_data_q != '0);

    // NOTE: defaults first so no path through this block leaves a value unassigned
    // and no latch is inferred.
    always_comb begin
        err_count_d = err_count_q;
        err_flag_d  = err_flag_q;
        if (clear_err) begin
            err_count_d = '0;
            err_flag_d  = 1'b0;
        end else if (mismatch) begin
            err_flag_d = 1'b1;
            if (err_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
                err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_synced  = m_synced_q;
    assign err_count = err_count_q;
    assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_jesd204_rx_descrambler.sv
// Scoreboard bench for jesd204_rx_descrambler: directed vectors, a bit-serial
// transmitter model for the round trip, and a narrow-counter instance for saturation.
module tb_jesd204_rx_descrambler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        check_en;
    logic        clear_err;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_synced;
    logic [15:0] err_count;
    logic        err_flag;

    logic        s_ready_sat;
    logic        m_valid_sat;
    logic [31:0] m_data_sat;
    logic        m_synced_sat;
    logic [1:0]  err_count_sat;
    logic        err_flag_sat;

    always #5 clk = ~clk;

    jesd204_rx_descrambler #(.ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .check_en(check_en),
        .clear_err(clear_err), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_synced(m_synced), .err_count(err_count),
        .err_flag(err_flag)
    );

    jesd204_rx_descrambler #(.ERR_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .check_en(check_en),
        .clear_err(clear_err), .s_valid(s_valid), .s_ready(s_ready_sat),
        .s_data(s_data), .m_valid(m_valid_sat), .m_ready(m_ready),
        .m_data(m_data_sat), .m_synced(m_synced_sat), .err_count(err_count_sat),
        .err_flag(err_flag_sat)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        synced;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        tb_sync  = 1'b0;
    logic [14:0] tx_h     = 15'h7FFF;
    logic        rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tb_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
        return r;
    endfunction

    // Bit-serial transmitter: s[n] = d[n] ^ s[n-14] ^ s[n-15], first line bit = swizzled bit 31.
    task automatic tx_scramble(input logic [31:0] d, output logic [31:0] line);
        logic [31:0] dsw;
        logic [31:0] lsw;
        logic        s;
        dsw = tb_swap(d);
        lsw = '0;
        for (int b = 31; b >= 0; b--) begin
            s      = dsw[b] ^ tx_h[13] ^ tx_h[14];
            lsw[b] = s;
            tx_h   = {tx_h[13:0], s};
        end
        line = tb_swap(lsw);
    endtask

    // Monitor: pops on every output handshake and checks held outputs during stalls.
    initial begin
        logic [31:0] held_data;
        logic        held_synced;
        logic        held_stall;
        exp_t        e;
        held_stall  = 1'b0;
        held_data   = '0;
        held_synced = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (held_stall)
                    check("stall_hold", {31'd0, m_valid, m_synced, m_data}, {31'd0, 1'b1, held_synced, held_data});
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got 0x%0h with no expected word queued", m_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("m_data", {32'd0, m_data}, {32'd0, e.data});
                        check("m_synced", {63'd0, m_synced}, {63'd0, e.synced});
                    end
                end
                held_stall  = m_valid && !m_ready;
                held_data   = m_data;
                held_synced = m_synced;
            end else begin
                held_stall = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    end

    // All tasks below start and end at posedge+1.
    task automatic do_reset();
        rst_n   = 1'b0;
        sb_q.delete();
        tb_sync = 1'b0;
        tx_h    = 15'h7FFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_enable(input logic en);
        enable = en;
        if (!en) tb_sync = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] exp_d);
        logic exp_s;
        logic accepted;
        exp_s    = enable && tb_sync;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (s_ready) begin
                sb_q.push_back('{data: exp_d, synced: exp_s});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word 0x%0h not accepted", d);
        end
        tb_sync = enable;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [31:0] line;
        rst_n = 1'b0; enable = 1'b0; check_en = 1'b0; clear_err = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;

        // Reset values
        do_reset();
        check("rst_m_valid",   {63'd0, m_valid},   64'd0);
        check("rst_m_data",    {32'd0, m_data},    64'd0);
        check("rst_m_synced",  {63'd0, m_synced},  64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_err_flag",  {63'd0, err_flag},  64'd0);
        check("rst_s_ready",   {63'd0, s_ready},   64'd1);
        check("rst_sat_state", {28'd0, m_valid_sat, m_synced_sat, err_count_sat, err_flag_sat, m_data_sat},
              {28'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0});

        // Zero stream from the seed
        set_enable(1'b1);
        check_en = 1'b1;
        send(32'h0000_0000, 32'h0000_0200);
        send(32'h0000_0000, 32'h0000_0000);
        drain();
        check("zero_err_count", {48'd0, err_count}, 64'd0);
        check("zero_err_flag",  {63'd0, err_flag},  64'd0);

        // All-ones line stream is a fixed point
        check_en = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // Bypass, then descramble from the history it left behind (state 15'h3412)
        do_reset();
        set_enable(1'b0);
        send(32'h1234_5678, 32'h1234_5678);
        set_enable(1'b1);
        send(32'h0000_0000, 32'h0000_6CB8);
        send(32'h0000_0000, 32'h0000_0000);
        drain();

        // Checker: flips in a synced zero stream
        do_reset();
        set_enable(1'b1);
        check_en = 1'b1;
        send(32'h0000_0000, 32'h0000_0200);
        send(32'h0000_0000, 32'h0000_0000);
        send(32'h0000_0080, 32'h0000_0380);
        send(32'h0000_0000, 32'h0000_0000);
        send(32'h2000_0000, 32'h2000_0000);
        send(32'h0000_0000, 32'h0000_C000);
        send(32'h0000_0080, 32'h0000_0380);
        send(32'h0000_0000, 32'h0000_0000);
        drain();
        check("chk_err_count", {48'd0, err_count},    64'd4);
        check("chk_err_flag",  {63'd0, err_flag},     64'd1);
        check("sat_err_count", {62'd0, err_count_sat}, 64'd3);
        check("sat_err_flag",  {63'd0, err_flag_sat}, 64'd1);

        // clear_err coinciding with a mismatch handshake wins
        send(32'h0000_0080, 32'h0000_0380);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("clr_err_count", {48'd0, err_count},     64'd0);
        check("clr_err_flag",  {63'd0, err_flag},      64'd0);
        check("clr_sat_count", {62'd0, err_count_sat}, 64'd0);
        send(32'h0000_0000, 32'h0000_0000);
        drain();
        check("post_clr_count", {48'd0, err_count}, 64'd0);

        // Round trip with random stalls on both sides
        check_en = 1'b0;
        do_reset();
        set_enable(1'b1);
        rand_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            word = $urandom;
            tx_scramble(word, line);
            send(line, word);
        end
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        drain();

        // Reset while a word is held under backpressure
        do_reset();
        set_enable(1'b1);
        m_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("stalled_valid", {63'd0, m_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid",  {63'd0, m_valid},  64'd0);
        check("midrst_m_data",   {32'd0, m_data},   64'd0);
        check("midrst_m_synced", {63'd0, m_synced}, 64'd0);
        sb_q.delete();
        tb_sync = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jesd204_rx_descrambler.md
# jesd204_rx_descrambler

Receive-side JESD204B descrambler for one 32-bit lane: it recovers octets with the self-synchronising polynomial 1 + x^14 + x^15. It sits between the lane's byte/frame alignment logic and the transport-layer deframer, and sends data on through a registered valid/ready stage. It also tracks descrambler synchronisation and provides a test-mode checker that counts non-zero payload words when the transmitter scrambles an all-zero stream.

## Interface
Parameters:
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  lane clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = descramble; 0 = bypass (data passes unchanged).
- check_en  in  1  enables the zero-payload checker.
- clear_err  in  1  synchronous clear of err_count and err_flag.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  32  scrambled word; octet 0 (first on the line) is bits [7:0], MSB first within each octet.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  32  descrambled word, same octet order as s_data.
- m_synced  out  1  sideband qualifying m_data: the word was descrambled from line-derived state only.
- err_count  out  ERR_CNT_WIDTH  saturating count of checker mismatches.
- err_flag  out  1  sticky; set on any mismatch.

## Operation
- Swizzle: sw = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]}. The first line bit is sw[31].
- Form full[46:0] = {state[14:0], sw}. Compute d[i] = full[i+15] ^ full[i+14] ^ sw[i] for i = 0..31.
- The output is the unswizzle of d, or of sw when enable=0.
- On every accepted input word, state <= sw[14:0]. This happens regardless of enable, so bypass keeps the history current.
- Reset value of state is 15'h7FFF, which matches the transmitter seed.
- Sync FSM, two states:
  - UNSYNC: entered at reset and whenever enable=0. An accepted word while enable=1 moves the FSM to SYNCED; that word itself is emitted with m_synced=0.
  - SYNCED: every accepted word is emitted with m_synced=1. enable=0 returns the FSM to UNSYNC, effective from that cycle's accepted word.
- Checker: on an output handshake (m_valid && m_ready) with check_en=1, m_synced=1 and m_data != 0:
  - err_count increments, saturating at all-ones;
  - err_flag is set.
- clear_err has priority over a same-cycle mismatch: the result is count 0, flag 0.
- Words with m_synced=0 are never checked.

## Timing
- Reset values: m_valid=0, m_data=0, m_synced=0, err_count=0, err_flag=0, state=7FFF, FSM=UNSYNC.
- s_ready = !m_valid || m_ready. It is combinational from m_ready; no other combinational path exists.
- Latency is 1 cycle. A word accepted in cycle n appears on m_data in cycle n+1.
- Throughput is one word per cycle while m_ready=1.
- Backpressure: while m_valid && !m_ready, m_data and m_synced hold stable, s_ready=0, and state does not advance.
- Accept with no input: m_valid falls to 0 on the next edge if no new word is accepted.
- Changing enable while stalled has no effect on the held word. It applies to the next accepted word.
- Asserting rst_n low mid-stream clears everything immediately. The first word after release is treated as a first word (m_synced=0).

## Structure
- Package jesd204_pkg holds:
  - SCR_SEED = 15'h7FFF;
  - tap constants 14 and 15;
  - byte-swap function octet_swap(32-bit);
  - FSM state typedef (UNSYNC, SYNCED).
- Sub-module jesd204_descramble_core: purely combinational, mapping (state, sw) to (d, next_state). It is reusable by a later multi-lane wrapper.
- The top level owns the output register, the handshake, the FSM and the checker.

## Test plan
- Zero stream: enable=1, check_en=1, feed 0x00000000 twice after reset, m_ready=1.
  - Word 1 gives m_data=0x00000200, m_synced=0.
  - Word 2 gives 0x00000000, m_synced=1.
  - err_count=0.
- All-ones: feed 0xFFFFFFFF from reset with enable=1. Every output is 0xFFFFFFFF.
- Bypass: enable=0, feed 0x12345678. Expect 0x12345678 one cycle later, m_synced=0. state afterwards is the low 15 bits of sw, i.e. 15'h3412 (sw=0x78563412).
- Round trip: scramble 1000 random words with the transmitter model (seed 7FFF), then descramble them with random m_ready/s_valid stalls.
  - All words match.
  - Outputs are held stable during stalls.
  - No word is dropped or duplicated.
- Checker: synced zero stream with one injected bit flip.
  - One input bit flip corrupts 3 output bits across 1-2 words; err_flag=1 and err_count = words affected.
  - clear_err in the same cycle as a mismatch gives count 0.
  - Counter saturates with ERR_CNT_WIDTH=2 at 3.
- Reset mid-stream: assert rst_n low while m_valid=1 and stalled. Outputs are zero immediately; after release the first word has m_synced=0.
